// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/data ports, the arbiter and the fixed-latency memory.
// The arbiter takes the slave modport; the pipeline plus memory side takes master.
interface mem_port_arbiter_if;
    // Each port holds *_req and its payload until *_rvalid; *_gnt marks the cycle the
    // access is issued to memory, *_rvalid the single cycle its response is returned.
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  dm_wsel;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_wsel;
    logic [31:0] mem_rdata;

    logic        stall_f;
    logic        stall_m;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wsel,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wsel,
        output stall_f, stall_m
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wsel,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wsel,
        input  stall_f, stall_m
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports.
// Define ARB_STARVE_GUARD_EN to compile in the fetch starvation guard (starve_cnt).
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus,
    output logic              dbg_state_o
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT);
    localparam logic       OWNER_IF = 1'b0;
    localparam logic       OWNER_DM = 1'b1;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] lat_cnt_q, lat_cnt_d;

    logic any_req;
    logic fetch_prio;
    logic pick_fetch;
    logic if_gnt_c, dm_gnt_c;
    logic if_rvalid_c, dm_rvalid_c;

    assign any_req    = bus.if_req | bus.dm_req;
    // Data is the older instruction, so it wins ties unless fetch has been starved.
    assign pick_fetch = bus.if_req & (~bus.dm_req | fetch_prio);

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign fetch_prio = (starve_cnt_q == STARVE_LAST);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt_c) begin
            starve_cnt_d = 4'd0;
        end else if (dm_gnt_c && bus.if_req) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // The threshold only matters when the guard is compiled in.
    logic unused_starve_max;
    assign unused_starve_max = |STARVE_MAX;
    assign fetch_prio        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_cnt_d   = lat_cnt_q;
        if_gnt_c    = 1'b0;
        dm_gnt_c    = 1'b0;
        if_rvalid_c = 1'b0;
        dm_rvalid_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    if_gnt_c  = pick_fetch;
                    dm_gnt_c  = ~pick_fetch;
                    owner_d   = pick_fetch ? OWNER_IF : OWNER_DM;
                    lat_cnt_d = 4'd1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Response cycle never overlaps a new grant; the count holds until reload.
                if (lat_cnt_q == LAT_LAST) begin
                    if_rvalid_c = (owner_q == OWNER_IF);
                    dm_rvalid_c = (owner_q == OWNER_DM);
                    state_d     = ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_IF;
            lat_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Every output, including the combinational strobes, is forced low during reset.
    assign bus.if_gnt    = rst_n & if_gnt_c;
    assign bus.dm_gnt    = rst_n & dm_gnt_c;
    assign bus.if_rvalid = rst_n & if_rvalid_c;
    assign bus.dm_rvalid = rst_n & dm_rvalid_c;
    assign bus.if_rdata  = rst_n ? bus.mem_rdata : 32'd0;
    assign bus.dm_rdata  = rst_n ? bus.mem_rdata : 32'd0;

    assign bus.mem_req   = rst_n & (if_gnt_c | dm_gnt_c);
    assign bus.mem_we    = rst_n & dm_gnt_c & bus.dm_we;
    // Address idles on the data port so it toggles less between accesses.
    assign bus.mem_addr  = !rst_n ? 32'd0 : (if_gnt_c ? bus.if_addr : bus.dm_addr);
    assign bus.mem_wdata = rst_n ? bus.dm_wdata : 32'd0;
    assign bus.mem_wsel  = rst_n ? bus.dm_wsel : 2'd0;

    assign bus.stall_f   = rst_n & bus.if_req & ~if_rvalid_c;
    assign bus.stall_m   = rst_n & bus.dm_req & ~dm_rvalid_c;

    assign dbg_state_o   = (state_q == ST_BUSY);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance driven from a vector
// table plus hand sequences, and a MEM_LAT=1 instance for back-to-back loads.
module tb_mem_port_arbiter;
    localparam int unsigned LAT = 2;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus1 ();
    logic dbg_state;
    logic dbg_state1;

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state_o(dbg_state)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state_o(dbg_state1)
    );

    // Memory models: word array with a read pipeline, contents rebuilt on reset.
    logic [31:0] mem [0:255];
    logic [31:0] rd_pipe [0:LAT-1];
    logic [31:0] rd1_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            for (int i = 0; i < LAT; i++) rd_pipe[i] <= 32'd0;
        end else begin
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            rd_pipe[0] <= 32'd0;
            if (bus.mem_req) begin
                if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
                else rd_pipe[0] <= mem[bus.mem_addr[9:2]];
            end
        end
    end
    assign bus.mem_rdata = rd_pipe[LAT-1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd1_q <= 32'd0;
        else rd1_q <= bus1.mem_req ? mem[bus1.mem_addr[9:2]] : 32'd0;
    end
    assign bus1.mem_rdata = rd1_q;

    // Requesters must hold their request until the response.
    logic if_pend, dm_pend;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pend <= 1'b0;
            dm_pend <= 1'b0;
        end else begin
            assert (!(if_pend && !bus.if_req && !bus.if_rvalid))
                else $error("protocol violation: if_req dropped before if_rvalid");
            assert (!(dm_pend && !bus.dm_req && !bus.dm_rvalid))
                else $error("protocol violation: dm_req dropped before dm_rvalid");
            if (bus.if_gnt) if_pend <= 1'b1;
            else if (bus.if_rvalid) if_pend <= 1'b0;
            if (bus.dm_gnt) dm_pend <= 1'b1;
            else if (bus.dm_rvalid) dm_pend <= 1'b0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'd0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'd0;
        bus.dm_wdata  = 32'd0;
        bus.dm_wsel   = 2'd0;
        bus1.if_req   = 1'b0;
        bus1.if_addr  = 32'd0;
        bus1.dm_req   = 1'b0;
        bus1.dm_we    = 1'b0;
        bus1.dm_addr  = 32'd0;
        bus1.dm_wdata = 32'd0;
        bus1.dm_wsel  = 2'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dmr;
        logic        we;
        logic [31:0] dma;
        logic [31:0] wd;
        logic [1:0]  ws;
        logic        e_ignt, e_dgnt, e_irv, e_drv, e_mreq, e_mwe;
        logic [31:0] e_maddr;
        logic        e_sf, e_sm, e_chk;
        logic [31:0] e_rd;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    logic [0:0] exp_q [$];
    logic [0:0] got_q [$];

    initial begin
        // ifr ifa dmr we dma wd ws | ignt dgnt irv drv mreq mwe maddr | sf sm chk rd
        vecs[0]  = '{Y, 32'h10, N, N, 32'h0,   32'h0,         2'd0, Y, N, N, N, Y, N, 32'h10,  Y, N, N, 32'h0};
        vecs[1]  = '{Y, 32'h10, N, N, 32'h0,   32'h0,         2'd0, N, N, N, N, N, N, 32'h0,   Y, N, N, 32'h0};
        vecs[2]  = '{Y, 32'h10, N, N, 32'h0,   32'h0,         2'd0, N, N, Y, N, N, N, 32'h0,   N, N, Y, 32'hA000_0004};
        vecs[3]  = '{N, 32'h0,  N, N, 32'h0,   32'h0,         2'd0, N, N, N, N, N, N, 32'h0,   N, N, N, 32'h0};
        vecs[4]  = '{N, 32'h0,  Y, Y, 32'h100, 32'hDEAD_BEEF, 2'd2, N, Y, N, N, Y, Y, 32'h100, N, Y, N, 32'h0};
        vecs[5]  = '{N, 32'h0,  Y, Y, 32'h100, 32'hDEAD_BEEF, 2'd2, N, N, N, N, N, N, 32'h0,   N, Y, N, 32'h0};
        vecs[6]  = '{N, 32'h0,  Y, Y, 32'h100, 32'hDEAD_BEEF, 2'd2, N, N, N, Y, N, N, 32'h0,   N, N, N, 32'h0};
        vecs[7]  = '{N, 32'h0,  Y, N, 32'h100, 32'h0,         2'd0, N, Y, N, N, Y, N, 32'h100, N, Y, N, 32'h0};
        vecs[8]  = '{N, 32'h0,  Y, N, 32'h100, 32'h0,         2'd0, N, N, N, N, N, N, 32'h0,   N, Y, N, 32'h0};
        vecs[9]  = '{N, 32'h0,  Y, N, 32'h100, 32'h0,         2'd0, N, N, N, Y, N, N, 32'h0,   N, N, Y, 32'hDEAD_BEEF};
        vecs[10] = '{Y, 32'h20, Y, N, 32'h40,  32'h0,         2'd0, N, Y, N, N, Y, N, 32'h40,  Y, Y, N, 32'h0};
        vecs[11] = '{Y, 32'h20, Y, N, 32'h40,  32'h0,         2'd0, N, N, N, N, N, N, 32'h0,   Y, Y, N, 32'h0};
        vecs[12] = '{Y, 32'h20, Y, N, 32'h40,  32'h0,         2'd0, N, N, N, Y, N, N, 32'h0,   Y, N, Y, 32'hA000_0010};
        vecs[13] = '{Y, 32'h20, N, N, 32'h0,   32'h0,         2'd0, Y, N, N, N, Y, N, 32'h20,  Y, N, N, 32'h0};
        vecs[14] = '{Y, 32'h20, N, N, 32'h0,   32'h0,         2'd0, N, N, N, N, N, N, 32'h0,   Y, N, N, 32'h0};
        vecs[15] = '{Y, 32'h20, N, N, 32'h0,   32'h0,         2'd0, N, N, Y, N, N, N, 32'h0,   N, N, Y, 32'hA000_0008};
        vecs[16] = '{N, 32'h0,  N, N, 32'h0,   32'h0,         2'd0, N, N, N, N, N, N, 32'h0,   N, N, N, 32'h0};

        // Reset: strobes stay low even with live requests.
        clear_inputs();
        rst_n        = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h44;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h55;
        bus.dm_wdata = 32'h1234_5678;
        bus.dm_wsel  = 2'd3;
        @(negedge clk);
        check("rst_if_gnt",    bus.if_gnt, 0);
        check("rst_dm_gnt",    bus.dm_gnt, 0);
        check("rst_mem_req",   bus.mem_req, 0);
        check("rst_mem_we",    bus.mem_we, 0);
        check("rst_mem_addr",  bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_wsel",  32'(bus.mem_wsel), 0);
        check("rst_if_rvalid", bus.if_rvalid, 0);
        check("rst_dm_rvalid", bus.dm_rvalid, 0);
        check("rst_if_rdata",  bus.if_rdata, 0);
        check("rst_stall_f",   bus.stall_f, 0);
        check("rst_stall_m",   bus.stall_m, 0);
        check("rst_state",     dbg_state, 0);
        next_cycle();
        clear_inputs();
        rst_n = 1'b1;

        // Fetch, store, load-back and contended access from the table.
        for (int i = 0; i < NV; i++) begin
            bus.if_req   = vecs[i].ifr;
            bus.if_addr  = vecs[i].ifa;
            bus.dm_req   = vecs[i].dmr;
            bus.dm_we    = vecs[i].we;
            bus.dm_addr  = vecs[i].dma;
            bus.dm_wdata = vecs[i].wd;
            bus.dm_wsel  = vecs[i].ws;
            @(negedge clk);
            check($sformatf("row%0d_if_gnt", i),    bus.if_gnt,    vecs[i].e_ignt);
            check($sformatf("row%0d_dm_gnt", i),    bus.dm_gnt,    vecs[i].e_dgnt);
            check($sformatf("row%0d_if_rvalid", i), bus.if_rvalid, vecs[i].e_irv);
            check($sformatf("row%0d_dm_rvalid", i), bus.dm_rvalid, vecs[i].e_drv);
            check($sformatf("row%0d_mem_req", i),   bus.mem_req,   vecs[i].e_mreq);
            check($sformatf("row%0d_mem_we", i),    bus.mem_we,    vecs[i].e_mwe);
            check($sformatf("row%0d_stall_f", i),   bus.stall_f,   vecs[i].e_sf);
            check($sformatf("row%0d_stall_m", i),   bus.stall_m,   vecs[i].e_sm);
            if (vecs[i].e_mreq) begin
                check($sformatf("row%0d_mem_addr", i), bus.mem_addr, vecs[i].e_maddr);
            end
            if (vecs[i].e_mreq && vecs[i].e_mwe) begin
                check($sformatf("row%0d_mem_wdata", i), bus.mem_wdata, vecs[i].wd);
                check($sformatf("row%0d_mem_wsel", i), 32'(bus.mem_wsel), 32'(vecs[i].ws));
            end
            if (vecs[i].e_chk) begin
                check($sformatf("row%0d_if_rdata", i), bus.if_rdata, vecs[i].e_rd);
                check($sformatf("row%0d_dm_rdata", i), bus.dm_rdata, vecs[i].e_rd);
            end
            next_cycle();
        end

        // Both ports requesting continuously: record the first eight grants.
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h20;
        bus.dm_req  = 1'b1;
        bus.dm_addr = 32'h40;
        for (int c = 0; c < 40 && got_q.size() < 8; c++) begin
            @(negedge clk);
            if (bus.if_gnt) got_q.push_back(1'b1);
            if (bus.dm_gnt) got_q.push_back(1'b0);
            next_cycle();
        end
        check("starve_grant_count", 32'(got_q.size()), 8);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("starve_grant%0d_is_fetch", i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end

        // Reset in the cycle after a grant aborts the access.
        clear_inputs();
        rst_n = 1'b0;
        next_cycle();
        rst_n       = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        @(negedge clk);
        check("abort_first_grant", bus.if_gnt, 1);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_in_rst_rvalid", bus.if_rvalid, 0);
        check("abort_in_rst_stall_f", bus.stall_f, 0);
        check("abort_in_rst_mem_req", bus.mem_req, 0);
        check("abort_in_rst_state", dbg_state, 0);
        next_cycle();
        rst_n       = 1'b1;
        bus.if_addr = 32'h30;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("abort_c%0d_if_gnt", c), bus.if_gnt, (c == 0));
            check($sformatf("abort_c%0d_if_rvalid", c), bus.if_rvalid, (c == 2));
            if (c == 2) check("abort_new_rdata", bus.if_rdata, 32'hA000_000C);
            next_cycle();
        end
        bus.if_req = 1'b0;

        // MEM_LAT=1: back-to-back loads on the second instance.
        bus1.dm_req = 1'b1;
        bus1.dm_we  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus1.dm_addr = 32'(4 * (c / 2));
            @(negedge clk);
            check($sformatf("lat1_c%0d_dm_gnt", c), bus1.dm_gnt, (c % 2 == 0));
            check($sformatf("lat1_c%0d_mem_req", c), bus1.mem_req, (c % 2 == 0));
            check($sformatf("lat1_c%0d_dm_rvalid", c), bus1.dm_rvalid, (c % 2 == 1));
            if (c % 2 == 1) begin
                check($sformatf("lat1_c%0d_dm_rdata", c), bus1.dm_rdata, 32'hA000_0000 | 32'(c / 2));
            end
            next_cycle();
        end
        bus1.dm_req = 1'b0;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch port (F stage) and data port (M stage). It arbitrates requests, sequences each access through a latency counter, and returns read data or write acknowledges. It also produces per-port stall signals that the pipeline control uses to freeze F or M while an access is pending.

## Interface
- `MEM_LAT`, 2: cycles from issue to response, legal range 1..15.
- `STARVE_MAX`, 3: consecutive lost contended arbitrations fetch tolerates before being forced to win. Used only with the guard enabled; legal range 1..15.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request. Held with `if_addr` until `if_rvalid`.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch access issued this cycle.
- `if_rvalid` out 1: fetch data valid, one-cycle pulse.
- `if_rdata` out 32: fetch data. Equals `mem_rdata`; qualify with `if_rvalid`.
- `dm_req` in 1: data request. Held with the other `dm_*` inputs until `dm_rvalid`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_addr` in 32: data byte address.
- `dm_wdata` in 32: store data.
- `dm_wsel` in 2: store size, passed through to memory.
- `dm_gnt` out 1: data access issued this cycle.
- `dm_rvalid` out 1: load data valid, or store acknowledge; one-cycle pulse.
- `dm_rdata` out 32: load data. Equals `mem_rdata`.
- `mem_req` out 1: issue strobe to memory, one cycle per access.
- `mem_we` out 1: write enable, qualified by `mem_req`.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_wsel` out 2: memory write size.
- `mem_rdata` in 32: memory read data, valid exactly `MEM_LAT` cycles after `mem_req`.
- `stall_f` out 1: `if_req & ~if_rvalid`.
- `stall_m` out 1: `dm_req & ~dm_rvalid`.

## Operation
- State machine states:
  - IDLE: arbitrates every cycle.
  - BUSY: one access is in flight; holds `owner` (0 = fetch, 1 = data) and `lat_cnt`.
- IDLE with no requests: all strobes are 0.
- IDLE with any request: the winner is selected combinationally.
  - `mem_req`=1 and the matching `*_gnt`=1 in the same cycle.
  - `mem_addr`, `mem_we`, `mem_wdata`, `mem_wsel` are muxed from the winner. Fetch drives `mem_we`=0.
  - Next state is BUSY, `lat_cnt`=1, `owner` latched.
- Winner rules:
  - Only one port requesting: that port wins.
  - Both requesting: data wins, since M is the older instruction.
- BUSY: `lat_cnt` increments each cycle.
  - When `lat_cnt`==`MEM_LAT`, the owner's `*_rvalid`=1, and next state is IDLE.
  - With `MEM_LAT`=1 the response arrives on the first BUSY cycle.
- No new grant is issued in BUSY, including the response cycle.
- Requests arriving in BUSY wait; the matching `stall_*` output stays high.
- A requester that deasserts before its response is a protocol violation. The in-flight access still completes and its rvalid still pulses. The bench flags this with an assertion.
- `mem_addr`/`mem_wdata` are don't-care when `mem_req`=0. They are driven from the data port for lower toggle.

## Timing
- Every output is 0 while `rst_n`=0, including all combinational strobes.
- State resets to IDLE, and `lat_cnt`, `owner`, `starve_cnt` reset to 0.
- Latency: an access issued in cycle t (grant) gets its rvalid in cycle t+`MEM_LAT`.
- Next grant is in cycle t+`MEM_LAT`+1 at the earliest.
- Peak throughput is one access per `MEM_LAT`+1 cycles.
- A request asserted in IDLE is granted in the same cycle: zero-cycle arbitration.
- Reset asserted mid-access: the access is aborted asynchronously, and no rvalid is produced after reset release. Memory is reset by the same `rst_n`.
- Counters are sized 4 bits; `lat_cnt` never wraps, because it reloads on each grant.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: a 4-bit `starve_cnt` is compiled in.
  - Increments on each IDLE cycle where both ports request and data wins.
  - Clears whenever fetch is granted.
  - When `starve_cnt`==`STARVE_MAX`, the next contended arbitration goes to fetch.
- `ARB_STARVE_GUARD_EN` undefined: fixed data priority, and `starve_cnt` is absent.

## Test plan
- Reset, then fetch only: `if_req`=1, `if_addr`=0x10, `MEM_LAT`=2.
  - Expect `if_gnt`/`mem_req` in cycle 0 with `mem_addr`=0x10.
  - Expect `if_rvalid` in cycle 2 with `if_rdata`=`mem_rdata`.
  - Expect `stall_f`=1 in cycles 0-1 and 0 in cycle 2.
- Store: `dm_req`=1, `dm_we`=1, `dm_addr`=0x100, `dm_wdata`=0xDEADBEEF, `dm_wsel`=2.
  - Expect `mem_we`=1 with these values in the grant cycle.
  - Expect `dm_rvalid` 2 cycles later, and the memory readback returns 0xDEADBEEF.
- Simultaneous requests: data granted in cycle 0 with `dm_rvalid` in cycle 2. Fetch is granted in cycle 3 with `if_rvalid` in cycle 5. `stall_f` stays high in cycles 0-4.
- Guard on, `STARVE_MAX`=3, both ports continuously re-requesting: grant sequence D,D,D,F,D,D,D,F. With the guard off, fetch is never granted.
- Reset pulse in the cycle after a grant: no rvalid ever appears for that access. After release, `if_req`=1 is granted on the first cycle.
- `MEM_LAT`=1, back-to-back loads: grants in cycles 0,2,4 and `dm_rvalid` in cycles 1,3,5.
